dmem_port_arbiter: RTL and testbench

Arbitrates one shared 64-bit data-memory port between two requesters:
- the pipeline MEM stage (core);
- a debug/program-loader master (dbg).

It sequences each access through a request/ready handshake with the memory. It produces the core stall signal that the hazard logic ANDs into PC_Write / IF_ID_Write so the pipeline freezes while a core access is outstanding.

---
 rtl/dmem_port_arbiter_if.sv | 50 +++++
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: core, debug and memory-side signals of the
// shared data-memory port, seen from the arbiter (slave) or its environment.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_done;
   logic              core_stall;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_done;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              bus_err;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_rdata, core_done, core_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_done,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output bus_err
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_rdata, core_done, core_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_done,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  bus_err
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin core/debug arbiter for one data-memory port.
// Optional BUSY watchdog with sticky bus_err: define DMEM_ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                clk,
   input logic                reset,
   dmem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e            state_q, state_d;
   logic              last_dbg_q, last_dbg_d;
   logic              gnt_dbg_q, gnt_dbg_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              core_done_q, core_done_d;
   logic              dbg_done_q, dbg_done_d;
   logic              bus_err_q, bus_err_d;
   logic              pick_dbg;
   logic [DATA_W-1:0] rd_val;
   logic              tmo;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter is zero outside BUSY, so it is clear on every BUSY entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY) cnt_d = cnt_q + 1'b1;
   end

   assign tmo = (state_q == BUSY) &&
                (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   // On a tie the requester opposite the last grant wins.
   assign pick_dbg = (bus.core_req && bus.dbg_req) ? ~last_dbg_q
                                                   : bus.dbg_req;
   assign rd_val   = mem_we_q ? '0 : bus.mem_rdata;

   always_comb begin
      state_d      = state_q;
      last_dbg_d   = last_dbg_q;
      gnt_dbg_d    = gnt_dbg_q;
      mem_req_d    = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      core_rdata_d = core_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      core_done_d  = 1'b0;
      dbg_done_d   = 1'b0;
      bus_err_d    = bus_err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.core_req || bus.dbg_req) begin
               state_d     = BUSY;
               gnt_dbg_d   = pick_dbg;
               last_dbg_d  = pick_dbg;
               mem_req_d   = 1'b1;
               mem_we_d    = pick_dbg ? bus.dbg_we : bus.core_we;
               mem_addr_d  = pick_dbg ? bus.dbg_addr : bus.core_addr;
               mem_wdata_d = pick_dbg ? bus.dbg_wdata : bus.core_wdata;
            end
         end
         BUSY: begin
            if (bus.mem_ready || tmo) begin
               state_d     = DONE;
               core_done_d = ~gnt_dbg_q;
               dbg_done_d  = gnt_dbg_q;
               if (gnt_dbg_q) dbg_rdata_d  = bus.mem_ready ? rd_val : '0;
               else           core_rdata_d = bus.mem_ready ? rd_val : '0;
               if (!bus.mem_ready) bus_err_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_dbg_q   <= 1'b1;
         gnt_dbg_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
         core_done_q  <= 1'b0;
         dbg_done_q   <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_dbg_q   <= last_dbg_d;
         gnt_dbg_q    <= gnt_dbg_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         core_rdata_q <= core_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         core_done_q  <= core_done_d;
         dbg_done_q   <= dbg_done_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.core_rdata = core_rdata_q;
   assign bus.dbg_rdata  = dbg_rdata_q;
   assign bus.core_done  = core_done_q;
   assign bus.dbg_done   = dbg_done_q;
   assign bus.core_stall = bus.core_req & ~core_done_q;
   assign bus.bus_err    = bus_err_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenario bench for dmem_port_arbiter,
// including the DMEM_ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_dmem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   dmem_port_arbiter #(
      .ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   task automatic idle_inputs();
      bus.core_req   = 1'b0;
      bus.core_we    = 1'b0;
      bus.core_addr  = '0;
      bus.core_wdata = '0;
      bus.dbg_req    = 1'b0;
      bus.dbg_we     = 1'b0;
      bus.dbg_addr   = '0;
      bus.dbg_wdata  = '0;
      bus.mem_rdata  = '0;
      bus.mem_ready  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int bad = 0;
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.core_done, bus.dbg_done,
           bus.bus_err, bus.core_stall} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 000000",
                  {bus.mem_req, bus.mem_we, bus.core_done,
                   bus.dbg_done, bus.bus_err, bus.core_stall});
      end
      checks++;
      if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h wdata=%h want 0",
                  bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if (bus.core_rdata !== 64'h0 || bus.dbg_rdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata: core=%h dbg=%h want 0",
                  bus.core_rdata, bus.dbg_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      // stray mem_ready while idle must be ignored
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 64'h5A5A;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         #1;
         if (bus.core_done || bus.dbg_done || bus.mem_req) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL idle_ready_ignored: got %0d events want 0", bad);
      end
   endtask

   task automatic test_core_load();
      int stall_n = 0;
      int req_n = 0;
      int req_at = -1;
      int done_n = 0;
      int done_at = -1;
      bus.core_we   = 1'b0;
      bus.core_addr = 64'h10;
      bus.core_req  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.mem_ready = (i == 3);
         bus.mem_rdata = (i == 3) ? 64'hDEADBEEF : 64'h0;
         #1;
         if (bus.core_stall) stall_n++;
         if (bus.mem_req) begin
            req_n++;
            req_at = i;
            checks++;
            if (bus.mem_addr !== 64'h10 || bus.mem_we !== 1'b0) begin
               errors++;
               $display("FAIL load_bus: addr=%h we=%b want 10/0",
                        bus.mem_addr, bus.mem_we);
            end
         end
         if (bus.core_done) begin
            done_n++;
            done_at = i;
            checks++;
            if (bus.core_rdata !== 64'hDEADBEEF) begin
               errors++;
               $display("FAIL load_rdata: got %h want deadbeef",
                        bus.core_rdata);
            end
            bus.core_req = 1'b0;
         end
         if (bus.dbg_done) done_n += 10;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      checks++;
      if (stall_n !== 4) begin
         errors++;
         $display("FAIL load_stall: got %0d cycles want 4", stall_n);
      end
      checks++;
      if (req_n !== 1 || req_at !== 1) begin
         errors++;
         $display("FAIL load_mem_req: n=%0d at=%0d want 1 at 1",
                  req_n, req_at);
      end
      checks++;
      if (done_n !== 1 || done_at !== 4) begin
         errors++;
         $display("FAIL load_done: n=%0d at=%0d want 1 at 4",
                  done_n, done_at);
      end
      checks++;
      if (bus.core_rdata !== 64'hDEADBEEF) begin
         errors++;
         $display("FAIL load_hold: got %h want deadbeef", bus.core_rdata);
      end
   endtask

   task automatic test_both_first();
      logic [63:0] order [2];
      int req_n = 0;
      int cdone = 0;
      int ddone = 0;
      int first = -1;
      do_reset();
      bus.core_addr = 64'h100;
      bus.dbg_addr  = 64'h200;
      bus.core_req  = 1'b1;
      bus.dbg_req   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (bus.mem_req) begin
            if (req_n < 2) order[req_n] = bus.mem_addr;
            req_n++;
         end
         if (bus.core_done) begin
            cdone++;
            if (first < 0) first = 0;
            checks++;
            if (bus.core_rdata !== 64'h5100) begin
               errors++;
               $display("FAIL both_core_rdata: got %h want 5100",
                        bus.core_rdata);
            end
            bus.core_req = 1'b0;
         end
         if (bus.dbg_done) begin
            ddone++;
            if (first < 0) first = 1;
            checks++;
            if (bus.dbg_rdata !== 64'h5200) begin
               errors++;
               $display("FAIL both_dbg_rdata: got %h want 5200",
                        bus.dbg_rdata);
            end
            bus.dbg_req = 1'b0;
         end
         bus.mem_ready = bus.mem_req;
         bus.mem_rdata = bus.mem_addr + 64'h5000;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      checks++;
      if (req_n !== 2 || order[0] !== 64'h100 || order[1] !== 64'h200) begin
         errors++;
         $display("FAIL both_order: n=%0d a0=%h a1=%h want 2 100 200",
                  req_n, order[0], order[1]);
      end
      checks++;
      if (cdone !== 1 || ddone !== 1 || first !== 0) begin
         errors++;
         $display("FAIL both_done: c=%0d d=%0d first=%0d want 1 1 0",
                  cdone, ddone, first);
      end
   endtask

   task automatic test_round_robin();
      logic [63:0] exp_addr [6];
      int g = 0;
      int cur_dbg = 0;
      int wrong = 0;
      int done_n = 0;
      exp_addr = '{64'h300, 64'h400, 64'h300, 64'h400, 64'h300, 64'h400};
      do_reset();
      bus.core_addr = 64'h300;
      bus.dbg_addr  = 64'h400;
      bus.core_req  = 1'b1;
      bus.dbg_req   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.mem_req) begin
            if (g < 6) begin
               checks++;
               if (bus.mem_addr !== exp_addr[g]) begin
                  errors++;
                  $display("FAIL rr_grant%0d: got %h want %h",
                           g, bus.mem_addr, exp_addr[g]);
               end
            end
            cur_dbg = g % 2;
            g++;
         end
         if (bus.core_done && cur_dbg != 0) wrong++;
         if (bus.dbg_done && cur_dbg == 0) wrong++;
         if (bus.core_done || bus.dbg_done) done_n++;
         if (done_n == 6) begin
            bus.core_req = 1'b0;
            bus.dbg_req  = 1'b0;
         end
         bus.mem_ready = bus.mem_req;
         bus.mem_rdata = bus.mem_addr + 64'h5000;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      checks++;
      if (g !== 6 || done_n !== 6 || wrong !== 0) begin
         errors++;
         $display("FAIL rr_count: grants=%0d dones=%0d wrong=%0d want 6 6 0",
                  g, done_n, wrong);
      end
   endtask

   task automatic test_back_to_back();
      int r0 = -1;
      int r1 = -1;
      int done_n = 0;
      bus.core_addr = 64'h500;
      bus.core_req  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (bus.mem_req) begin
            if (r0 < 0) r0 = i;
            else if (r1 < 0) r1 = i;
         end
         if (bus.core_done) begin
            done_n++;
            if (done_n == 2) bus.core_req = 1'b0;
         end
         bus.mem_ready = bus.mem_req;
         bus.mem_rdata = 64'h5500;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      checks++;
      if (r0 !== 1 || r1 !== 4 || done_n !== 2) begin
         errors++;
         $display("FAIL b2b: req at %0d,%0d dones=%0d want 1,4 and 2",
                  r0, r1, done_n);
      end
   endtask

   task automatic test_dbg_write();
      int bad = 0;
      int busy_n = 0;
      int done_n = 0;
      int done_at = -1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 64'h20;
      bus.dbg_wdata = 64'h1234;
      bus.dbg_req   = 1'b1;
      bus.mem_rdata = 64'hAAAA5555;
      for (int i = 0; i < 10; i++) begin
         if (i >= 1) begin
            bus.dbg_addr  = 64'hFF;
            bus.dbg_wdata = 64'hFF;
         end
         bus.mem_ready = (i == 4);
         #1;
         if (i >= 1 && i <= 4) begin
            busy_n++;
            if (bus.mem_addr !== 64'h20 || bus.mem_wdata !== 64'h1234 ||
                bus.mem_we !== 1'b1) bad++;
         end
         if (bus.core_done) bad++;
         if (bus.dbg_done) begin
            done_n++;
            done_at = i;
            checks++;
            if (bus.dbg_rdata !== 64'h0) begin
               errors++;
               $display("FAIL wr_rdata: got %h want 0", bus.dbg_rdata);
            end
            bus.dbg_req = 1'b0;
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      bus.dbg_we    = 1'b0;
      checks++;
      if (bad !== 0 || busy_n !== 4) begin
         errors++;
         $display("FAIL wr_hold: bad=%0d samples=%0d want 0 and 4",
                  bad, busy_n);
      end
      checks++;
      if (done_n !== 1 || done_at !== 5) begin
         errors++;
         $display("FAIL wr_done: n=%0d at=%0d want 1 at 5", done_n, done_at);
      end
      checks++;
      if (bus.core_rdata !== 64'h5500) begin
         errors++;
         $display("FAIL rdata_hold: got %h want 5500", bus.core_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      int done_n = 0;
      bus.core_addr = 64'h40;
      bus.core_req  = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy: mem_req=%b want 1", bus.mem_req);
      end
      reset = 1'b0;
      bus.core_req = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.core_done, bus.dbg_done,
           bus.bus_err} !== 5'b0 || bus.mem_addr !== 64'h0 ||
          bus.core_rdata !== 64'h0 || bus.dbg_rdata !== 64'h0) begin
         errors++;
         $display("FAIL abort_clear: req=%b addr=%h crd=%h want all 0",
                  bus.mem_req, bus.mem_addr, bus.core_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = 1'b1;
         @(negedge clk);
         #1;
         if (bus.core_done || bus.dbg_done || bus.mem_req) bad++;
      end
      bus.mem_ready = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL abort_leftover: got %0d events want 0", bad);
      end
      @(negedge clk);
      bus.core_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (bus.core_done) begin
            done_n++;
            checks++;
            if (bus.core_rdata !== 64'h77 || i !== 2) begin
               errors++;
               $display("FAIL abort_fresh: rdata=%h at %0d want 77 at 2",
                        bus.core_rdata, i);
            end
            bus.core_req = 1'b0;
         end
         bus.mem_ready = bus.mem_req;
         bus.mem_rdata = 64'h77;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      checks++;
      if (done_n !== 1) begin
         errors++;
         $display("FAIL abort_fresh_n: got %0d dones want 1", done_n);
      end
   endtask

   task automatic test_timeout();
      int bad = 0;
      int done_n = 0;
      int done_at = -1;
      bus.core_addr = 64'h80;
      bus.mem_rdata = 64'h99;
      bus.mem_ready = 1'b0;
      bus.core_req  = 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
      for (int i = 0; i < 30; i++) begin
         #1;
         if (done_n == 0 && bus.bus_err) bad++;
         if (bus.core_done) begin
            done_n++;
            done_at = i;
            checks++;
            if (bus.core_rdata !== 64'h0 || bus.bus_err !== 1'b1) begin
               errors++;
               $display("FAIL tmo_done: rdata=%h err=%b want 0 1",
                        bus.core_rdata, bus.bus_err);
            end
            bus.core_req = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (done_n !== 1 || done_at !== 17 || bad !== 0) begin
         errors++;
         $display("FAIL tmo_timing: n=%0d at=%0d early=%0d want 1 17 0",
                  done_n, done_at, bad);
      end
      checks++;
      if (bus.bus_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_sticky: bus_err=%b want 1", bus.bus_err);
      end
`else
      for (int i = 0; i < 120; i++) begin
         #1;
         if (bus.core_done || bus.bus_err) bad++;
         if (i > 0 && bus.mem_addr !== 64'h80) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL nowdog_wait: got %0d events want 0", bad);
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.core_done !== 1'b1 || bus.core_rdata !== 64'h99 ||
          bus.bus_err !== 1'b0) begin
         errors++;
         $display("FAIL nowdog_done: done=%b rdata=%h err=%b want 1 99 0",
                  bus.core_done, bus.core_rdata, bus.bus_err);
      end
      bus.core_req = 1'b0;
      done_n  = 1;
      done_at = 0;
      @(negedge clk);
`endif
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_core_load();
      test_both_first();
      test_round_robin();
      test_back_to_back();
      test_dbg_write();
      test_reset_mid();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
